lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store memory controller. It sits directly upstream of the load byte-extraction stage.
- Accepts one load or store from the execute stage and computes the effective address.
- Drives the data-memory request/grant/rvalid handshake and generates store byte lanes.
- Returns the raw 32-bit memory word, the byte offset and funct3 to the load-extraction stage, which performs sign/zero extension.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the access is aborted with an error (range 1..65535).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- req_rs1  in  32  base register.
- req_imm  in  32  immediate offset.
- req_wdata  in  32  store data (rs2).
- mem_req  out  1  memory request, held until granted.
- mem_addr  out  32  word-aligned address {ea[31:2],2'b00}.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  read data valid / write acknowledge.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  captured word (0 for stores and errors).
- rsp_funct3  out  3  funct3 of the completed op.
- rsp_offset  out  2  ea[1:0] of the completed op.
- rsp_err  out  1  access error (illegal funct3, timeout, or misalignment when enabled).

Behaviour:
- Reset
  - State = IDLE; the timeout counter clears.
  - All outputs are 0 except req_ready = 1.
  - Reset mid-access abandons the access: no rsp_valid, and mem_req drops on the next edge.
- Effective address
  - ea = req_rs1 + req_imm, mod 2^32.
  - ea, we, funct3 and wdata are registered when req_valid & req_ready.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE -> REQ on acceptance of a legal op.
  - IDLE -> RESP (rsp_err = 1, no memory access) on an illegal funct3: 011/110/111 for loads; 011/100/101/110/111 for stores.
  - REQ: mem_req = 1 with stable mem_addr/mem_we/mem_be/mem_wdata; on mem_gnt go to WAIT.
  - WAIT: mem_req = 0; on mem_rvalid capture mem_rdata (loads only) and go to RESP. mem_rvalid in REQ is ignored.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_* hold their values until the next RESP.
- Latency
  - Minimum 3 cycles from the acceptance edge to rsp_valid: gnt in the first REQ cycle, rvalid in the first WAIT cycle.
  - Error path: rsp_valid on the cycle after acceptance.
- Store lanes, off = ea[1:0]
  - SB: mem_be = 4'b0001 << off; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = off[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_be = 1111, mem_we = 0.
- Timeout
  - The counter clears on acceptance and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err = 1 and mem_req = 0.
  - A late mem_rvalid arriving in IDLE/RESP is ignored.
- Single outstanding access: no pipelining.

Optional Feature:
- MISALIGN_TRAP_EN defined
  - H/HU/SH with ea[0] = 1, or W/SW with ea[1:0] != 0, goes IDLE -> RESP with rsp_err = 1.
  - No mem_req is issued.
- MISALIGN_TRAP_EN undefined
  - The access proceeds to the word-aligned address; byte enables follow the lane rules above (ea[0] ignored for halfwords, off ignored for words).
  - rsp_err is never set for misalignment.

Test Plan:
- LW, rs1 = 0x1000, imm = 0x4, gnt and rvalid immediate, rdata = 0xDEADBEEF -> mem_addr = 0x1004, mem_be = 1111; rsp_valid 3 cycles after accept; rsp_rdata = 0xDEADBEEF, rsp_offset = 0, rsp_err = 0.
- SB, ea = 0x2003, wdata = 0x000000A5 -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1; rsp_rdata = 0.
- LH, ea = 0x3002, gnt delayed 4 cycles -> mem_req held 5 cycles with a stable address; rsp_offset = 2, rsp_funct3 = 001.
- Load with rvalid never asserted, TIMEOUT_CYCLES = 8 -> rsp_valid with rsp_err = 1 after 8 cycles in REQ/WAIT; a later rvalid produces no response.
- Load funct3 = 011 -> rsp_valid with rsp_err = 1 the cycle after accept, mem_req never asserted.
- SW to ea = 0x4002 -> with MISALIGN_TRAP_EN: rsp_err = 1, no mem_req. Without it: mem_addr = 0x4000, mem_be = 1111.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store memory controller feeding the load byte-extraction stage.
// Accepts one op from execute, forms ea = rs1 + imm, runs one data-memory
// req/gnt/rvalid access and returns the raw word, byte offset and funct3.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid_i/req_ready_o          execute-stage handshake (ready only in IDLE)
//   req_we_i, req_funct3_i           store select, access size/sign
//   req_rs1_i, req_imm_i, req_wdata_i base, offset, store data
//   mem_req_o/mem_gnt_i              request held until granted
//   mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  word address, lanes, replicated data
//   mem_rvalid_i, mem_rdata_i        read data / write acknowledge
//   rsp_valid_o                      one-cycle completion pulse
//   rsp_rdata_o, rsp_funct3_o, rsp_offset_o, rsp_err_o  held completion info
// Build option: define MISALIGN_TRAP_EN to fail misaligned H/W accesses without
// touching memory; otherwise they go to the word-aligned address.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_imm_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [2:0]  rsp_funct3_o,
    output logic [1:0]  rsp_offset_o,
    output logic        rsp_err_o
);
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] ea_q, ea_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d, rf3_q, rf3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ea, wd;
    logic [3:0]  be;
    logic        bad_f3, misalign, tmo, in_req;

    assign ea = req_rs1_i + req_imm_i;
    // 011/11x are never legal; stores additionally reject the unsigned forms 1xx
    assign bad_f3 = req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11 || (req_we_i && req_funct3_i[2]);
`ifdef MISALIGN_TRAP_EN
    assign misalign = (req_funct3_i[1:0] == 2'b01 && ea[0]) || (req_funct3_i[1:0] == 2'b10 && ea[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    // fires on the cycle that would be the TIMEOUT_CYCLES-th spent in REQ/WAIT
    assign tmo = cnt_q + 16'd1 == TMO;

    // legal stores only use funct3 000/001/010, so bit 1 alone marks a word
    assign be = !we_q || f3_q[1] ? 4'hF : f3_q[0] ? (ea_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ea_q[1:0];
    assign wd = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};

    assign in_req       = state_q == REQ;
    assign req_ready_o  = state_q == IDLE;
    assign mem_req_o    = in_req;
    assign mem_addr_o   = in_req ? {ea_q[31:2], 2'b00} : '0;
    assign mem_we_o     = in_req && we_q;
    assign mem_be_o     = in_req ? be : '0;
    assign mem_wdata_o  = in_req ? wd : '0;
    assign rsp_valid_o  = state_q == RESP;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_funct3_o = rf3_q;
    assign rsp_offset_o = off_q;
    assign rsp_err_o    = err_q;

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rf3_d   = rf3_q;
        off_d   = off_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                ea_d    = ea;
                we_d    = req_we_i;
                f3_d    = req_funct3_i;
                wdata_d = req_wdata_i;
                cnt_d   = '0;
                state_d = bad_f3 || misalign ? RESP : REQ;
                err_d   = 1'b1;
                rdata_d = '0;
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : mem_rdata_i;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: state_d = IDLE;
        endcase
        // err/rdata are staged early on acceptance but only become visible with RESP
        if (state_d == RESP && state_q != RESP) begin
            rf3_d = f3_d;
            off_d = ea_d[1:0];
        end else begin
            err_d   = state_q == IDLE ? err_q : err_d;
            rdata_d = state_q == IDLE ? rdata_q : rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ea_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rf3_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rf3_q   <= rf3_d;
            off_q   <= off_d;
        end
    end
endmodule
